ber_symbol_checker: RTL and testbench



---
 rtl/ber_chk_pkg.sv | 17 +
 rtl/ber_chk_align.sv | 37 +++
 rtl/ber_symbol_checker.sv | 173 +++++++++++++++++
 tb/tb_ber_symbol_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_chk_pkg.sv
// Shared types, constants and the saturating-increment helper for the PAM4 BER checker.
// Pure declarations: no latency, no flow control.
package ber_chk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  localparam int HIST_BINS = 8;

  // Callers widen to 64 bits and truncate back; counters are never wider than 64.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] lim);
    return (v >= lim) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/ber_chk_align.sv
// ALIGN_DLY-deep 2-bit delay line giving the reference symbol for each channel output.
// Latency ALIGN_DLY cycles; free-running every cycle, no backpressure.
module ber_chk_align #(
  parameter int ALIGN_DLY = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic [1:0] sym_in,
  output logic [1:0] sym_out
);

  logic [1:0] line_q [ALIGN_DLY];
  logic [1:0] line_d [ALIGN_DLY];

  always_comb begin
    line_d[0] = sym_in;
    for (int i = 1; i < ALIGN_DLY; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      for (int i = 0; i < ALIGN_DLY; i++) begin
        line_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < ALIGN_DLY; i++) begin
        line_q[i] <= line_d[i];
      end
    end
  end

  assign sym_out = line_q[ALIGN_DLY-1];

endmodule

// File: rtl/ber_symbol_checker.sv
// PAM4 symbol checker: symbol/error/wrap/burst statistics, optional histogram under BER_CHK_HIST_EN.
// Outputs registered, 1 cycle after the compare; no backpressure, statistics freeze once done.
module ber_symbol_checker
  import ber_chk_pkg::*;
#(
  parameter int ALIGN_DLY = 1,
  parameter int CNT_W     = 48,
  parameter int BURST_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [1:0]         sym_tx,
  input  logic [1:0]         sym_rx,
  input  logic               rx_valid,
  input  logic               clear,
  input  logic [CNT_W-1:0]   target_syms,
  output logic [CNT_W-1:0]   sym_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   wrap_cnt,
  output logic [BURST_W-1:0] burst_cnt,
  output logic [BURST_W-1:0] max_burst,
  output logic               done
`ifdef BER_CHK_HIST_EN
  ,
  output logic [HIST_BINS*BURST_W-1:0] burst_hist
`endif
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [BURST_W-1:0] BURST_MAX = '1;

  logic [1:0] ref_sym;

  ber_chk_align #(
    .ALIGN_DLY (ALIGN_DLY)
  ) u_align (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (clear),
    .sym_in  (sym_tx),
    .sym_out (ref_sym)
  );

  logic               cmp;
  logic               err;
  logic               wrap;
  logic               burst_live;
  burst_state_t       state_q, state_d;
  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURST_W-1:0] max_burst_q, max_burst_d;
  logic [BURST_W-1:0] cur_len_q, cur_len_d;
  logic               done_q, done_d;

  assign cmp  = rx_valid && !done_q;
  assign err  = cmp && (sym_rx != ref_sym);
  // Only the 0<->3 pair is a modulo wrap; all other mismatches are adjacent-level slips.
  assign wrap = err && (((sym_rx == 2'd0) && (ref_sym == 2'd3)) ||
                        ((sym_rx == 2'd3) && (ref_sym == 2'd0)));

  always_comb begin
    sym_cnt_d   = sym_cnt_q;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    burst_cnt_d = burst_cnt_q;
    max_burst_d = max_burst_q;
    cur_len_d   = cur_len_q;
    done_d      = done_q;
    burst_live  = (state_q == BURST);

    if (cmp) begin
      sym_cnt_d = CNT_W'(sat_inc(64'(sym_cnt_q), 64'(CNT_MAX)));
      if (err) begin
        err_cnt_d = CNT_W'(sat_inc(64'(err_cnt_q), 64'(CNT_MAX)));
        if (wrap) begin
          wrap_cnt_d = CNT_W'(sat_inc(64'(wrap_cnt_q), 64'(CNT_MAX)));
        end
        if (state_q == IDLE) begin
          burst_cnt_d = BURST_W'(sat_inc(64'(burst_cnt_q), 64'(BURST_MAX)));
          cur_len_d   = BURST_W'(1);
        end else begin
          cur_len_d = BURST_W'(sat_inc(64'(cur_len_q), 64'(BURST_MAX)));
        end
        if (cur_len_d > max_burst_q) begin
          max_burst_d = cur_len_d;
        end
        burst_live = 1'b1;
      end else begin
        burst_live = 1'b0;
      end
      if ((target_syms != '0) && (sym_cnt_d == target_syms)) begin
        done_d = 1'b1;
      end
    end

    // Completion closes any open burst in the same cycle its last compare lands.
    if (done_d && !done_q) begin
      burst_live = 1'b0;
    end
    state_d = burst_live ? BURST : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      state_q     <= IDLE;
      sym_cnt_q   <= '0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      burst_cnt_q <= '0;
      max_burst_q <= '0;
      cur_len_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      max_burst_q <= max_burst_d;
      cur_len_q   <= cur_len_d;
      done_q      <= done_d;
    end
  end

  assign sym_cnt   = sym_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign burst_cnt = burst_cnt_q;
  assign max_burst = max_burst_q;
  assign done      = done_q;

`ifdef BER_CHK_HIST_EN
  logic [BURST_W-1:0] hist_q [HIST_BINS];
  logic [BURST_W-1:0] hist_d [HIST_BINS];
  logic               burst_close;
  logic [2:0]         bin_idx;

  always_comb begin
    // A burst closes when one was open (or opened this cycle) and the next state is IDLE.
    burst_close = ((state_q == BURST) || err) && (state_d == IDLE);
    bin_idx     = (cur_len_d >= BURST_W'(HIST_BINS)) ? 3'(HIST_BINS - 1)
                                                     : 3'(cur_len_d - BURST_W'(1));
    for (int i = 0; i < HIST_BINS; i++) begin
      hist_d[i] = hist_q[i];
    end
    if (burst_close) begin
      hist_d[bin_idx] = BURST_W'(sat_inc(64'(hist_q[bin_idx]), 64'(BURST_MAX)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      for (int i = 0; i < HIST_BINS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < HIST_BINS; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  always_comb begin
    burst_hist = '0;
    for (int i = 0; i < HIST_BINS; i++) begin
      burst_hist[i*BURST_W +: BURST_W] = hist_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_ber_symbol_checker.sv
// Directed bench for ber_symbol_checker with a cycle-accurate expectation queue.
module tb_ber_symbol_checker;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  sym_tx, sym_rx;
  logic        rx_valid, clear;
  logic [47:0] target_syms;
  logic [47:0] sym_cnt, err_cnt, wrap_cnt;
  logic [15:0] burst_cnt, max_burst;
  logic        done;
`ifdef BER_CHK_HIST_EN
  logic [127:0] burst_hist;
`endif

  ber_symbol_checker #(
    .ALIGN_DLY (1),
    .CNT_W     (48),
    .BURST_W   (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sym_tx      (sym_tx),
    .sym_rx      (sym_rx),
    .rx_valid    (rx_valid),
    .clear       (clear),
    .target_syms (target_syms),
    .sym_cnt     (sym_cnt),
    .err_cnt     (err_cnt),
    .wrap_cnt    (wrap_cnt),
    .burst_cnt   (burst_cnt),
    .max_burst   (max_burst),
    .done        (done)
`ifdef BER_CHK_HIST_EN
    ,
    .burst_hist  (burst_hist)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0]  sym;
    logic [47:0]  err;
    logic [47:0]  wrap;
    logic [15:0]  bcnt;
    logic [15:0]  mx;
    logic         done;
    logic [127:0] hist;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural reference state
  logic [47:0]  m_sym, m_err, m_wrap, tgt;
  logic [15:0]  m_bcnt, m_max, m_len;
  logic         m_inb, m_done;
  logic [127:0] m_hist;
  logic [1:0]   m_ref;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input exp_t e);
    chk("sb_sym_cnt",   128'(sym_cnt),   128'(e.sym));
    chk("sb_err_cnt",   128'(err_cnt),   128'(e.err));
    chk("sb_wrap_cnt",  128'(wrap_cnt),  128'(e.wrap));
    chk("sb_burst_cnt", 128'(burst_cnt), 128'(e.bcnt));
    chk("sb_max_burst", 128'(max_burst), 128'(e.mx));
    chk("sb_done",      128'(done),      128'(e.done));
`ifdef BER_CHK_HIST_EN
    chk("sb_hist",      burst_hist,      e.hist);
`endif
  endtask

  task automatic m_close();
    int b;
    b = (m_len >= 16'd8) ? 7 : int'(m_len) - 1;
    m_hist[b*16 +: 16] = m_hist[b*16 +: 16] + 16'd1;
    m_inb = 1'b0;
  endtask

  task automatic m_zero();
    m_sym = '0; m_err = '0; m_wrap = '0; m_bcnt = '0; m_max = '0; m_len = '0;
    m_inb = 1'b0; m_done = 1'b0; m_hist = '0; m_ref = 2'd0;
  endtask

  // One clock cycle: check last cycle's outputs, drive new inputs, predict their effect.
  // rx is the reference symbol plus delta (mod 4), so delta != 0 forces an error.
  task automatic cyc(input logic [1:0] tx, input logic [1:0] delta, input logic vld, input logic clr);
    logic [1:0] rx;
    exp_t       e;
    @(negedge clk);
    if (sb.size() > 0) sb_check(sb.pop_front());
    rx          = m_ref + delta;
    sym_tx      = tx;
    sym_rx      = rx;
    rx_valid    = vld;
    clear       = clr;
    target_syms = tgt;
    if (clr) begin
      m_zero();
    end else begin
      if (vld && !m_done) begin
        m_sym = m_sym + 48'd1;
        if (rx != m_ref) begin
          m_err = m_err + 48'd1;
          if ({rx, m_ref} == 4'b0011 || {rx, m_ref} == 4'b1100) m_wrap = m_wrap + 48'd1;
          if (!m_inb) begin
            m_inb  = 1'b1;
            m_bcnt = m_bcnt + 16'd1;
            m_len  = 16'd1;
          end else begin
            m_len = m_len + 16'd1;
          end
          if (m_len > m_max) m_max = m_len;
        end else if (m_inb) begin
          m_close();
        end
        if (tgt != 0 && m_sym == tgt) begin
          m_done = 1'b1;
          if (m_inb) m_close();
        end
      end
      m_ref = tx;
    end
    e.sym = m_sym; e.err = m_err; e.wrap = m_wrap; e.bcnt = m_bcnt;
    e.mx = m_max; e.done = m_done; e.hist = m_hist;
    sb.push_back(e);
  endtask

  function automatic logic [1:0] rnd();
    return 2'($urandom_range(0, 3));
  endfunction

  initial begin
    int blen [3];
    blen = '{3, 1, 5};
    rstn = 1'b0; sym_tx = 2'd0; sym_rx = 2'd0; rx_valid = 1'b0; clear = 1'b0;
    tgt = '0; target_syms = '0;
    m_zero();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sym_cnt",   128'(sym_cnt),   128'(0));
    chk("rst_err_cnt",   128'(err_cnt),   128'(0));
    chk("rst_wrap_cnt",  128'(wrap_cnt),  128'(0));
    chk("rst_burst_cnt", 128'(burst_cnt), 128'(0));
    chk("rst_max_burst", 128'(max_burst), 128'(0));
    chk("rst_done",      128'(done),      128'(0));
    rstn = 1'b1;

    // Error-free run of 100 symbols
    tgt = 48'd100;
    for (int i = 0; i < 100; i++) begin
      cyc(rnd(), 2'd0, 1'b1, 1'b0);
      if (i == 99) begin
        chk("ef_done_early", 128'(done),    128'(0));
        chk("ef_sym_99",     128'(sym_cnt), 128'(99));
      end
    end
    cyc(2'd0, 2'd0, 1'b0, 1'b0);
    chk("ef_done",      128'(done),      128'(1));
    chk("ef_sym_cnt",   128'(sym_cnt),   128'(100));
    chk("ef_err_cnt",   128'(err_cnt),   128'(0));
    chk("ef_burst_cnt", 128'(burst_cnt), 128'(0));

    // Injected bursts of 3, 1, 5 with alternating +1/-1 errors
    tgt = '0;
    cyc(rnd(), 2'd0, 1'b1, 1'b1);
    cyc(rnd(), 2'd0, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < blen[b]; k++) cyc(rnd(), (k % 2 == 0) ? 2'd1 : 2'd3, 1'b1, 1'b0);
      cyc(rnd(), 2'd0, 1'b1, 1'b0);
      cyc(rnd(), 2'd0, 1'b1, 1'b0);
    end
    cyc(2'd0, 2'd0, 1'b0, 1'b0);
    chk("inj_err_cnt",   128'(err_cnt),   128'(9));
    chk("inj_burst_cnt", 128'(burst_cnt), 128'(3));
    chk("inj_max_burst", 128'(max_burst), 128'(5));
`ifdef BER_CHK_HIST_EN
    chk("inj_bin0", 128'(burst_hist[0*16 +: 16]), 128'(1));
    chk("inj_bin2", 128'(burst_hist[2*16 +: 16]), 128'(1));
    chk("inj_bin4", 128'(burst_hist[4*16 +: 16]), 128'(1));
    chk("inj_bin1", 128'(burst_hist[1*16 +: 16]), 128'(0));
`endif

    // Wrap errors: 3->0, 0->3 twice each, then 1->2
    cyc(rnd(), 2'd0, 1'b1, 1'b1);
    cyc(2'd3, 2'd0, 1'b1, 1'b0);
    cyc(2'd0, 2'd1, 1'b1, 1'b0);
    cyc(2'd3, 2'd3, 1'b1, 1'b0);
    cyc(2'd0, 2'd1, 1'b1, 1'b0);
    cyc(2'd1, 2'd3, 1'b1, 1'b0);
    cyc(2'd0, 2'd1, 1'b1, 1'b0);
    chk("wrap_wrap_cnt4", 128'(wrap_cnt), 128'(4));
    chk("wrap_err_cnt4",  128'(err_cnt),  128'(4));
    cyc(2'd0, 2'd0, 1'b0, 1'b0);
    chk("wrap_wrap_hold", 128'(wrap_cnt), 128'(4));
    chk("wrap_err_cnt5",  128'(err_cnt),  128'(5));

    // Burst spanning a 4-cycle gap in valid data
    cyc(rnd(), 2'd0, 1'b1, 1'b1);
    cyc(rnd(), 2'd1, 1'b1, 1'b0);
    repeat (4) cyc(rnd(), 2'd0, 1'b0, 1'b0);
    cyc(rnd(), 2'd1, 1'b1, 1'b0);
    cyc(rnd(), 2'd0, 1'b1, 1'b0);
    cyc(2'd0, 2'd0, 1'b0, 1'b0);
    chk("gap_burst_cnt", 128'(burst_cnt), 128'(1));
    chk("gap_max_burst", 128'(max_burst), 128'(2));

    // Run completes in the middle of a burst
    tgt = 48'd10;
    cyc(rnd(), 2'd0, 1'b1, 1'b1);
    repeat (7) cyc(rnd(), 2'd0, 1'b1, 1'b0);
    repeat (3) cyc(rnd(), 2'd1, 1'b1, 1'b0);
    repeat (3) cyc(rnd(), 2'd1, 1'b1, 1'b0);
    cyc(2'd0, 2'd0, 1'b0, 1'b0);
    chk("dmb_done",      128'(done),      128'(1));
    chk("dmb_sym_cnt",   128'(sym_cnt),   128'(10));
    chk("dmb_err_cnt",   128'(err_cnt),   128'(3));
    chk("dmb_burst_cnt", 128'(burst_cnt), 128'(1));
    chk("dmb_max_burst", 128'(max_burst), 128'(3));
`ifdef BER_CHK_HIST_EN
    chk("dmb_bin2", 128'(burst_hist[2*16 +: 16]), 128'(1));
`endif

    // Clear arriving together with an erroneous compare mid-burst
    tgt = '0;
    cyc(rnd(), 2'd0, 1'b1, 1'b1);
    cyc(rnd(), 2'd1, 1'b1, 1'b0);
    cyc(rnd(), 2'd1, 1'b1, 1'b0);
    cyc(rnd(), 2'd1, 1'b1, 1'b1);
    cyc(rnd(), 2'd1, 1'b1, 1'b0);
    chk("clr_sym_cnt",   128'(sym_cnt),   128'(0));
    chk("clr_err_cnt",   128'(err_cnt),   128'(0));
    chk("clr_burst_cnt", 128'(burst_cnt), 128'(0));
    chk("clr_max_burst", 128'(max_burst), 128'(0));
    chk("clr_done",      128'(done),      128'(0));
    cyc(2'd0, 2'd0, 1'b0, 1'b0);
    chk("clr_new_burst", 128'(burst_cnt), 128'(1));
    chk("clr_new_err",   128'(err_cnt),   128'(1));

    @(negedge clk);
    while (sb.size() > 0) sb_check(sb.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
